// File: rtl/spi_resp_tx.sv
// SPI responder transmitter: one-word holding buffer feeding an MSB-first
// shift register. Frames are framed by an external master's select and
// serial clock, both already synchronized to clk_in.
module spi_resp_tx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_in,
  output logic                  ready_out,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic                  data_out,
  output logic                  done_out,
  output logic                  underrun_out,
  output logic [1:0]            state_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_full;
  logic                  r_sel_d;
  logic                  r_sclk_d;
  logic                  r_data;
  logic                  r_done;
  logic                  r_underrun;

  logic w_sel_fall;
  logic w_sel_rise;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_start;

  // Edges compare the input against last cycle's registered copy.
  assign w_sel_fall = r_sel_d & ~sel_in;
  assign w_sel_rise = ~r_sel_d & sel_in;
  assign w_clk_rise = ~r_sclk_d & data_clk_in;
  assign w_clk_fall = r_sclk_d & ~data_clk_in;
  assign w_start    = (r_state == IDLE) && w_sel_fall;

  // Register the master's select and serial clock for edge detection.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sel_d  <= 1'b1;
      r_sclk_d <= 1'b0;
    end else begin
      r_sel_d  <= sel_in;
      r_sclk_d <= data_clk_in;
    end
  end

  // Holding buffer: a frame start consumes the buffer state from before this
  // cycle, so a coincident load only lands when the buffer was empty.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_buf  <= '0;
      r_full <= 1'b0;
    end else if (w_start && r_full) begin
      r_full <= 1'b0;
    end else if (load_in && !r_full) begin
      r_buf  <= data_in;
      r_full <= 1'b1;
    end
  end

  // Frame FSM with registered serial data and status pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_data     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (w_sel_rise) begin
        // Deselect wins over everything: abort or normal frame end.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
        r_data  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_data <= 1'b0;
            if (w_sel_fall) begin
              r_state <= SHIFT;
              r_cnt   <= '0;
              if (r_full) begin
                r_shift <= r_buf;
                r_data  <= r_buf[DATA_WIDTH-1];
              end else begin
                r_shift    <= '0;
                r_underrun <= 1'b1;
              end
            end
          end
          SHIFT: begin
            if (w_clk_rise) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == LAST_BIT) begin
                r_state <= WAIT_DESEL;
                r_done  <= 1'b1;
                r_data  <= 1'b0;
              end
            end else if (w_clk_fall && (r_cnt != '0)) begin
              r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_data  <= r_shift[DATA_WIDTH-2];
            end
          end
          WAIT_DESEL: begin
            r_data <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_data  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_out    = ~r_full;
  assign data_out     = r_data;
  assign done_out     = r_done;
  assign underrun_out = r_underrun;
  assign state_out    = r_state;

endmodule
